specmd_pipe: RTL and testbench

- Parametrised, pipelined special-operand resolver for the FPU multiply/divide path.
- Takes per-operand class flags, signs and NaN fractions, and applies IEEE-754 special-case rules for mul or div.
- Emits the special result class, sign, NaN fraction and exception flags through a valid/ready pipeline of configurable depth.
- Sits beside the mantissa datapath; downstream result muxing uses is_special to override the normal result.

---
 rtl/specmd_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_specmd_pipe.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/specmd_pipe.sv
// specmd_pipe: pipelined special-operand resolver for the FPU multiply/divide path.
// Classifies both operands, applies the IEEE-754 special-case rules for mul or
// div and carries the resulting class, sign, NaN fraction and exception flags
// through a valid/ready register pipeline of STAGES stages.
// Optional feature: define SPECMD_STICKY_EN to get accumulating sticky
// invalid/divide-by-zero flags with a set-dominant clear.
module specmd_pipe #(
  parameter int MW     = 52,
  parameter int STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          fdiv,
  input  logic          sign_a,
  input  logic          sign_b,
  input  logic [3:0]    fla,
  input  logic [3:0]    flb,
  input  logic [MW-1:0] frac_a,
  input  logic [MW-1:0] frac_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          is_special,
  output logic [2:0]    res_cls,
  output logic          res_sign,
  output logic [MW-1:0] res_frac,
  output logic          exc_invalid,
  output logic          exc_divz,
  input  logic          clr_sticky,
  output logic          sticky_invalid,
  output logic          sticky_divz
);

  // Packed result word: {is_special, cls[2:0], sign, frac[MW-1:0], invalid, divz}
  localparam int DW = MW + 7;

  // Quiet bit / default NaN fraction: 1 followed by MW-1 zeros.
  localparam logic [MW-1:0] QBIT = {1'b1, {(MW-1){1'b0}}};

  localparam logic [2:0] CLS_NAN  = 3'b100;
  localparam logic [2:0] CLS_INF  = 3'b010;
  localparam logic [2:0] CLS_ZERO = 3'b001;

  // ---------------------------------------------------------------------------
  // Operand classification
  // ---------------------------------------------------------------------------
  logic a_snan, a_qnan, a_inf, a_zero, a_nan;
  logic b_snan, b_qnan, b_inf, b_zero, b_nan;

  // Decode class flags with priority snan > qnan > inf > zero so that a
  // malformed flag word (several bits set) still yields exactly one class.
  always_comb begin
    a_snan = fla[3];
    a_qnan = ~fla[3] & fla[2];
    a_inf  = (fla[3:2] == 2'b00) & fla[1];
    a_zero = (fla[3:1] == 3'b000) & fla[0];
    a_nan  = fla[3] | fla[2];
    b_snan = flb[3];
    b_qnan = ~flb[3] & flb[2];
    b_inf  = (flb[3:2] == 2'b00) & flb[1];
    b_zero = (flb[3:1] == 3'b000) & flb[0];
    b_nan  = flb[3] | flb[2];
  end

  // ---------------------------------------------------------------------------
  // Special-case resolution
  // ---------------------------------------------------------------------------
  logic          r_special;
  logic [2:0]    r_cls;
  logic          r_sign;
  logic [MW-1:0] r_frac;
  logic          r_inv;
  logic          r_divz;
  logic          src_sign;
  logic [MW-1:0] src_frac;
  logic          dflt_nan;
  logic [DW-1:0] r_word;

  // NaN payload source: operand a whenever a is any NaN, otherwise b.
  always_comb begin
    src_sign = a_nan ? sign_a : sign_b;
    src_frac = a_nan ? frac_a : frac_b;
  end

  // Invalid combinations that produce the default NaN.
  always_comb begin
    if (fdiv) begin
      dflt_nan = (a_zero & b_zero) | (a_inf & b_inf);
    end else begin
      dflt_nan = (a_inf & b_zero) | (a_zero & b_inf);
    end
  end

  // Apply the rules in priority order: sNaN, qNaN, default NaN, inf/zero.
  always_comb begin
    r_special = 1'b0;
    r_cls     = 3'b000;
    r_sign    = 1'b0;
    r_frac    = '0;
    r_inv     = 1'b0;
    r_divz    = 1'b0;
    if (a_snan | b_snan) begin
      // Signalling NaN is quieted by forcing the fraction MSB.
      r_special = 1'b1;
      r_cls     = CLS_NAN;
      r_sign    = src_sign;
      r_frac    = src_frac | QBIT;
      r_inv     = 1'b1;
    end else if (a_qnan | b_qnan) begin
      r_special = 1'b1;
      r_cls     = CLS_NAN;
      r_sign    = src_sign;
      r_frac    = src_frac;
    end else if (dflt_nan) begin
      r_special = 1'b1;
      r_cls     = CLS_NAN;
      r_frac    = QBIT;
      r_inv     = 1'b1;
    end else if (!fdiv) begin
      // Multiply: an infinity dominates, else a zero forces zero.
      if (a_inf | b_inf) begin
        r_special = 1'b1;
        r_cls     = CLS_INF;
        r_sign    = sign_a ^ sign_b;
      end else if (a_zero | b_zero) begin
        r_special = 1'b1;
        r_cls     = CLS_ZERO;
        r_sign    = sign_a ^ sign_b;
      end
    end else begin
      // Divide: inf/x = inf, x/inf = 0, 0/x = 0, finite/0 = inf with divz.
      if (a_inf) begin
        r_special = 1'b1;
        r_cls     = CLS_INF;
        r_sign    = sign_a ^ sign_b;
      end else if (b_inf) begin
        r_special = 1'b1;
        r_cls     = CLS_ZERO;
        r_sign    = sign_a ^ sign_b;
      end else if (a_zero) begin
        r_special = 1'b1;
        r_cls     = CLS_ZERO;
        r_sign    = sign_a ^ sign_b;
      end else if (b_zero) begin
        r_special = 1'b1;
        r_cls     = CLS_INF;
        r_sign    = sign_a ^ sign_b;
        r_divz    = 1'b1;
      end
    end
  end

  assign r_word = {r_special, r_cls, r_sign, r_frac, r_inv, r_divz};

  // ---------------------------------------------------------------------------
  // Valid/ready register pipeline
  // ---------------------------------------------------------------------------
  logic          stg_valid [STAGES];
  logic          stg_load  [STAGES];
  logic          stg_vin   [STAGES];
  logic [DW-1:0] stg_data  [STAGES];
  logic [DW-1:0] stg_din   [STAGES];

  // A stage may load when it is empty or its successor is taking its entry;
  // evaluated from the output end backwards so bubbles collapse under a stall.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stg_load[k] = 1'b0;
    end
    stg_load[STAGES-1] = ~stg_valid[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      stg_load[k] = ~stg_valid[k] | stg_load[k+1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stg_vin[gi] = in_valid;
        assign stg_din[gi] = r_word;
      end else begin : g_tail
        assign stg_vin[gi] = stg_valid[gi-1];
        assign stg_din[gi] = stg_data[gi-1];
      end

      // Stage register: take the upstream entry (or a bubble) when allowed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg_valid[gi] <= 1'b0;
          stg_data[gi]  <= '0;
        end else if (stg_load[gi]) begin
          stg_valid[gi] <= stg_vin[gi];
          stg_data[gi]  <= stg_din[gi];
        end
      end
    end
  endgenerate

  assign in_ready  = stg_load[0];
  assign out_valid = stg_valid[STAGES-1];
  assign {is_special, res_cls, res_sign, res_frac, exc_invalid, exc_divz} = stg_data[STAGES-1];

  // ---------------------------------------------------------------------------
  // Sticky exception flags
  // ---------------------------------------------------------------------------
`ifdef SPECMD_STICKY_EN
  logic sticky_invalid_reg;
  logic sticky_divz_reg;
  logic out_xfer;

  assign out_xfer = out_valid & out_ready;

  // Accumulate flags of transferred results; a new flag beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_invalid_reg <= 1'b0;
      sticky_divz_reg    <= 1'b0;
    end else begin
      sticky_invalid_reg <= (sticky_invalid_reg & ~clr_sticky) | (out_xfer & exc_invalid);
      sticky_divz_reg    <= (sticky_divz_reg & ~clr_sticky) | (out_xfer & exc_divz);
    end
  end

  assign sticky_invalid = sticky_invalid_reg;
  assign sticky_divz    = sticky_divz_reg;
`else
  logic unused_clr;
  assign unused_clr     = clr_sticky;
  assign sticky_invalid = 1'b0;
  assign sticky_divz    = 1'b0;
`endif

endmodule

// File: tb/tb_specmd_pipe.sv
// tb_specmd_pipe: self-checking bench for specmd_pipe (MW=52, STAGES=2).
// Directed test-plan cases, a stalled burst, randomized traffic against a
// class-based reference model, sticky-flag behaviour and mid-flight reset.
module tb_specmd_pipe;

  localparam int MW     = 52;
  localparam int STAGES = 2;
`ifdef SPECMD_STICKY_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif

  localparam logic [2:0] NAN  = 3'b100;
  localparam logic [2:0] INF  = 3'b010;
  localparam logic [2:0] ZERO = 3'b001;
  localparam logic [MW-1:0] DNAN = {1'b1, {(MW-1){1'b0}}};

  typedef enum int {C_SNAN, C_QNAN, C_INF, C_ZERO, C_FIN} cls_e;

  typedef struct packed {
    logic          sp;
    logic [2:0]    cls;
    logic          sg;
    logic [MW-1:0] fr;
    logic          inv;
    logic          dz;
  } res_t;

  typedef struct packed {
    logic          fdiv;
    logic          sa;
    logic          sb;
    logic [3:0]    fla;
    logic [3:0]    flb;
    logic [MW-1:0] fa;
    logic [MW-1:0] fb;
  } stim_t;

  typedef struct {
    res_t r;
    int   incyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, fdiv, sign_a, sign_b;
  logic [3:0]    fla, flb;
  logic [MW-1:0] frac_a, frac_b;
  logic          out_valid, out_ready, is_special;
  logic [2:0]    res_cls;
  logic          res_sign;
  logic [MW-1:0] res_frac;
  logic          exc_invalid, exc_divz, clr_sticky, sticky_invalid, sticky_divz;

  specmd_pipe #(.MW(MW), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .fdiv(fdiv), .sign_a(sign_a), .sign_b(sign_b),
    .fla(fla), .flb(flb), .frac_a(frac_a), .frac_b(frac_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .is_special(is_special), .res_cls(res_cls), .res_sign(res_sign),
    .res_frac(res_frac), .exc_invalid(exc_invalid), .exc_divz(exc_divz),
    .clr_sticky(clr_sticky), .sticky_invalid(sticky_invalid), .sticky_divz(sticky_divz)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   nout = 0;
  int   saw_block = 0;
  bit   lat_check = 1'b0;
  bit   last_acc = 1'b0;
  bit   hold_prev = 1'b0;
  bit   m_sk_inv = 1'b0;
  bit   m_sk_dz = 1'b0;
  res_t prev_o, last_o;
  exp_t expq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic cls_e classify(input logic [3:0] f);
    if (f[3]) return C_SNAN;
    if (f[2]) return C_QNAN;
    if (f[1]) return C_INF;
    if (f[0]) return C_ZERO;
    return C_FIN;
  endfunction

  // Reference model: IEEE-754 special-case outcome of a*b or a/b by class.
  function automatic res_t model(input stim_t s);
    cls_e ca;
    cls_e cb;
    res_t r;
    int   kind; // 0 normal, 1 default NaN, 2 infinity, 3 zero
    ca = classify(s.fla);
    cb = classify(s.flb);
    r = '0;
    if (ca == C_SNAN || cb == C_SNAN || ca == C_QNAN || cb == C_QNAN) begin
      r.sp  = 1'b1;
      r.cls = NAN;
      r.inv = (ca == C_SNAN || cb == C_SNAN);
      if (ca == C_SNAN || ca == C_QNAN) begin
        r.sg = s.sa;
        r.fr = s.fa;
      end else begin
        r.sg = s.sb;
        r.fr = s.fb;
      end
      if (r.inv) r.fr[MW-1] = 1'b1;
      return r;
    end
    kind = 0;
    if (s.fdiv) begin
      if ((ca == C_INF && cb == C_INF) || (ca == C_ZERO && cb == C_ZERO)) kind = 1;
      else if (ca == C_INF) kind = 2;
      else if (cb == C_INF) kind = 3;
      else if (ca == C_ZERO) kind = 3;
      else if (cb == C_ZERO) begin
        kind = 2;
        r.dz = 1'b1;
      end
    end else begin
      if ((ca == C_INF && cb == C_ZERO) || (ca == C_ZERO && cb == C_INF)) kind = 1;
      else if (ca == C_INF || cb == C_INF) kind = 2;
      else if (ca == C_ZERO || cb == C_ZERO) kind = 3;
    end
    case (kind)
      1: begin r.sp = 1'b1; r.cls = NAN; r.fr = DNAN; r.inv = 1'b1; end
      2: begin r.sp = 1'b1; r.cls = INF; r.sg = s.sa ^ s.sb; end
      3: begin r.sp = 1'b1; r.cls = ZERO; r.sg = s.sa ^ s.sb; end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] rand_fl();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0100;
      4: return 4'b1000;
      5: return 4'b0000;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    logic [63:0] t;
    s.fdiv = 1'($urandom_range(0, 1));
    s.sa   = 1'($urandom_range(0, 1));
    s.sb   = 1'($urandom_range(0, 1));
    s.fla  = rand_fl();
    s.flb  = rand_fl();
    t = {$urandom(), $urandom()};
    s.fa = t[MW-1:0];
    t = {$urandom(), $urandom()};
    s.fb = t[MW-1:0];
    return s;
  endfunction

  task automatic apply(input stim_t s);
    fdiv   = s.fdiv;
    sign_a = s.sa;
    sign_b = s.sb;
    fla    = s.fla;
    flb    = s.flb;
    frac_a = s.fa;
    frac_b = s.fb;
  endtask

  function automatic stim_t cur_stim();
    stim_t s;
    s = {fdiv, sign_a, sign_b, fla, flb, frac_a, frac_b};
    return s;
  endfunction

  // One clock: observe at the falling edge, then return 1 time unit after
  // the rising edge so the caller can drive the next cycle's inputs.
  task automatic cycle();
    res_t o;
    exp_t e;
    bit   xinv;
    bit   xdz;
    @(negedge clk);
    cyc++;
    xinv = 1'b0;
    xdz  = 1'b0;
    chk("sticky_invalid", sticky_invalid, m_sk_inv);
    chk("sticky_divz", sticky_divz, m_sk_dz);
    o = {is_special, res_cls, res_sign, res_frac, exc_invalid, exc_divz};
    if (hold_prev) begin
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_hold_data", o, prev_o);
    end
    hold_prev = out_valid && !out_ready;
    prev_o = o;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("spurious_output", out_valid, 0);
      end else begin
        e = expq.pop_front();
        chk("is_special", o.sp, e.r.sp);
        chk("res_cls", o.cls, e.r.cls);
        chk("res_sign", o.sg, e.r.sg);
        chk("res_frac", o.fr, e.r.fr);
        chk("exc_invalid", o.inv, e.r.inv);
        chk("exc_divz", o.dz, e.r.dz);
        if (lat_check) chk("latency", cyc - e.incyc, STAGES);
        xinv = e.r.inv;
        xdz  = e.r.dz;
        last_o = o;
        nout++;
      end
    end
    if (SE) begin
      m_sk_inv = (m_sk_inv && !clr_sticky) || xinv;
      m_sk_dz  = (m_sk_dz && !clr_sticky) || xdz;
    end
    last_acc = in_valid && in_ready;
    if (in_valid && !in_ready) saw_block++;
    if (last_acc) begin
      e.r = model(cur_stim());
      e.incyc = cyc;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input stim_t s);
    int n;
    apply(s);
    in_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 50);
    chk("send_accepted", last_acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 100) begin
      cycle();
      n++;
    end
    chk("drain_empty", expq.size(), 0);
  endtask

  function automatic stim_t mk(input logic d, input logic sa, input logic sb,
                               input logic [3:0] a, input logic [3:0] b,
                               input logic [MW-1:0] fa, input logic [MW-1:0] fb);
    stim_t s;
    s = {d, sa, sb, a, b, fa, fb};
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t burst [8];
    int    sent;
    int    bc;
    int    nstart;
    int    n;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr_sticky = 1'b0;
    apply('0);
    #1;
    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_is_special", is_special, 0);
    chk("rst_res_cls", res_cls, 0);
    chk("rst_res_frac", res_frac, 0);
    chk("rst_flags", {exc_invalid, exc_divz, sticky_invalid, sticky_divz}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // mul 0 x inf -> default NaN, invalid, latency STAGES
    lat_check = 1'b1;
    send(mk(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0010, '0, '0));
    drain();
    chk("tp_mul0inf_cls", last_o.cls, 3'b100);
    chk("tp_mul0inf_frac", last_o.fr, 52'h8000000000000);
    chk("tp_mul0inf_inv", last_o.inv, 1);

    // div finite/0 -> inf, sign 1, divz
    send(mk(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 52'h123456789abcd, '0));
    drain();
    chk("tp_divz_cls", last_o.cls, 3'b010);
    chk("tp_divz_sign", last_o.sg, 1);
    chk("tp_divz_flag", last_o.dz, 1);

    // div inf/inf -> default NaN
    send(mk(1'b1, 1'b1, 1'b1, 4'b0010, 4'b0010, '0, '0));
    drain();
    chk("tp_infinf_cls", last_o.cls, 3'b100);
    chk("tp_infinf_frac", last_o.fr, 52'h8000000000000);
    chk("tp_infinf_sign", last_o.sg, 0);
    chk("tp_infinf_inv", last_o.inv, 1);

    // sNaN a with qNaN b: a's payload, quieted
    send(mk(1'b0, 1'b1, 1'b0, 4'b1000, 4'b0100, 52'h0000000000001, 52'h8000000000005));
    drain();
    chk("tp_snan_frac", last_o.fr, 52'h8000000000001);
    chk("tp_snan_sign", last_o.sg, 1);
    chk("tp_snan_inv", last_o.inv, 1);

    // Back-to-back 8 inputs with out_ready low for burst cycles 3..6
    lat_check = 1'b0;
    for (int i = 0; i < 8; i++) burst[i] = rand_stim();
    sent = 0;
    bc = 0;
    saw_block = 0;
    nstart = nout;
    while ((sent < 8 || expq.size() > 0) && bc < 100) begin
      bc++;
      out_ready = !(bc >= 3 && bc <= 6);
      if (sent < 8) begin
        apply(burst[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      if (last_acc) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("burst_in_ready_dropped", saw_block > 0, 1);
    chk("burst_all_out", nout - nstart, 8);

    // Randomized traffic with random backpressure and sticky clears
    in_valid = 1'b0;
    last_acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || last_acc) begin
        apply(rand_stim());
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready  = ($urandom_range(0, 9) < 7);
      clr_sticky = ($urandom_range(0, 15) == 0);
      cycle();
    end
    in_valid = 1'b0;
    clr_sticky = 1'b0;
    out_ready = 1'b1;
    drain();

    // Sticky: clear, divz result, then clear together with an invalid transfer
    clr_sticky = 1'b1;
    cycle();
    clr_sticky = 1'b0;
    cycle();
    chk("sticky_cleared", {sticky_invalid, sticky_divz}, 0);
    send(mk(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001, '0, '0));
    drain();
    cycle();
    chk("sticky_divz_set", sticky_divz, SE);
    out_ready = 1'b0;
    send(mk(1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000, 52'h0000000000007, '0));
    n = 0;
    while (!out_valid && n < 20) begin
      cycle();
      n++;
    end
    chk("sticky_inv_pending", out_valid, 1);
    out_ready = 1'b1;
    clr_sticky = 1'b1;
    cycle();
    clr_sticky = 1'b0;
    chk("sticky_divz_after_clr", sticky_divz, 0);
    chk("sticky_inv_set_wins", sticky_invalid, SE);

    // Reset with two entries in flight
    out_ready = 1'b0;
    send(rand_stim());
    send(rand_stim());
    cycle();
    chk("pre_reset_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sticky", {sticky_invalid, sticky_divz}, 0);
    expq.delete();
    hold_prev = 1'b0;
    m_sk_inv = 1'b0;
    m_sk_dz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    nstart = nout;
    repeat (6) cycle();
    chk("no_stale_after_reset", nout - nstart, 0);
    chk("post_reset_out_valid", out_valid, 0);

    // Pipeline still works after reset
    lat_check = 1'b1;
    send(mk(1'b0, 1'b1, 1'b1, 4'b0010, 4'b0000, '0, '0));
    drain();
    chk("post_reset_inf_cls", last_o.cls, 3'b010);
    chk("post_reset_inf_sign", last_o.sg, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
